prng_stream_checker: RTL and testbench
======================================

PRNG_STREAM_CHECKER -- requirements
Module: prng_stream_checker

Interface
REQ-001 SHALL have ports: clk input 1 (clock, all logic on posedge); rst_n input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have port seed_valid input 1: one-cycle pulse marking seed_in valid.
REQ-003 SHALL have port seed_in input 32: seed of the sequence under check.
REQ-004 SHALL have port in_valid input 1: rand_num valid this cycle; gaps of any length allowed.
REQ-005 SHALL have port rand_num input 32: received random number.
REQ-006 SHALL have port busy output 1: high while a sequence check is in progress.
REQ-007 SHALL have port done output 1: one-cycle pulse when a check completes.
REQ-008 SHALL have port pass output 1: result, valid while done=1.
REQ-009 SHALL have port err_cnt output 9: number of mismatching samples in the current/last check.
REQ-010 SHALL have port first_err_idx output 8: index of the first mismatching sample.
REQ-011 SHALL have port timeout output 1: abort flag, valid while done=1.

Function
REQ-012 SHALL implement states IDLE, CHECK, REPORT.
REQ-013 In IDLE, seed_valid=1 SHALL perform all of the following:
- load expected <= xs(seed_in);
- clear the sample counter, err_cnt, first_err_idx and the mismatch-seen flag;
- go to CHECK.
REQ-014 xs(x) SHALL be three steps, 32-bit wrap, shifts are logical:
- t = x ^ (x<<13);
- t = t ^ (t>>17);
- result = t ^ (t<<5).
REQ-015 In CHECK, each cycle with in_valid=1 SHALL:
- compare rand_num with expected;
- then set expected <= xs(expected);
- increment the 8-bit sample counter, wrapping 255 to 0.
REQ-016 On a mismatch, err_cnt SHALL increment. It is 9-bit and cannot overflow, maximum value 256.
REQ-017 On the first mismatch only, first_err_idx SHALL capture the sample counter value. first_err_idx SHALL stay 0 if no mismatch occurs.
REQ-018 The check SHALL end when the 256th sample (counter=255) is accepted with in_valid=1. The next state is then REPORT.
REQ-019 That 256th sample's own comparison SHALL be included in err_cnt and pass.
REQ-020 In REPORT, for exactly one cycle:
- done=1;
- pass=1 iff err_cnt==0 and timeout==0;
- then return to IDLE.
REQ-021 busy SHALL be 1 in CHECK and REPORT and 0 in IDLE.
REQ-022 In IDLE, in_valid SHALL be ignored.
REQ-023 In CHECK and REPORT, seed_valid SHALL be ignored.
REQ-024 A seed_valid coincident with the REPORT cycle SHALL be dropped. The source must wait for busy=0.
REQ-025 err_cnt and first_err_idx SHALL hold their values after done until the next accepted seed_valid.
REQ-026 pass and timeout SHALL be 0 whenever done=0.
REQ-027 Latency from the last in_valid to the done pulse SHALL be exactly 1 cycle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst_n=0, all of the following SHALL be 0:
- state=IDLE;
- busy, done, pass, timeout;
- err_cnt, first_err_idx;
- expected, counter, watchdog.
REQ-030 Reset asserted mid-CHECK SHALL abort the check with no done pulse. After release the block SHALL wait in IDLE.

Configuration
REQ-031 Macro PRNG_CHECK_TIMEOUT_EN, when defined, SHALL add a 10-bit watchdog in CHECK:
- clear it on entry to CHECK and on every in_valid=1;
- otherwise increment it;
- on reaching 1023, go to REPORT with timeout=1, pass=0, and done pulsing.
REQ-032 A watchdog expiry coincident with in_valid=1 SHALL NOT fire. The sample SHALL be processed normally.
REQ-033 When PRNG_CHECK_TIMEOUT_EN is undefined:
- no watchdog logic SHALL exist;
- timeout SHALL be constant 0;
- CHECK SHALL wait indefinitely.

Verification
REQ-034 Seed sequence: seed_in=0x00000001, then 256 back-to-back correct samples, the first being 0x00042021 -> done one cycle after the last sample, pass=1, err_cnt=0, first_err_idx=0.
REQ-035 Single corruption: as REQ-034 but samples 5 and 200 each XOR 0x1 -> pass=0, err_cnt=2, first_err_idx=5; values held after done.
REQ-036 Gapped input: seed 0xDEADBEEF, correct samples with random 0-20 idle cycles between them -> pass=1; busy high continuously from the cycle after seed_valid until done.
REQ-037 Boundary: seed 0x00000000, expected stream all zero, all 256 samples 0xFFFFFFFF -> err_cnt=256, first_err_idx=0, pass=0; a seed_valid pulse during CHECK has no effect.
REQ-038 Reset and timeout: reset after 100 samples -> busy=0, no done, all outputs 0. With PRNG_CHECK_TIMEOUT_EN defined, seed then 10 samples then silence -> done with timeout=1, pass=0 exactly 1023 cycles after the last sample.

Source files
------------

// File: rtl/prng_stream_checker_if.sv
// Seed/sample stream and result bus of the xorshift32 stream checker.
// The master drives seed and samples; the slave (checker) returns status.
interface prng_stream_checker_if;
  logic        seed_valid;
  logic [31:0] seed_in;
  logic        in_valid;
  logic [31:0] rand_num;
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  err_cnt;
  logic [7:0]  first_err_idx;
  logic        timeout;

  modport master (
    output seed_valid, seed_in, in_valid, rand_num,
    input  busy, done, pass, err_cnt, first_err_idx, timeout
  );

  modport slave (
    input  seed_valid, seed_in, in_valid, rand_num,
    output busy, done, pass, err_cnt, first_err_idx, timeout
  );
endinterface

// File: rtl/prng_stream_checker.sv
// Checks a 256-sample xorshift32 stream against the sequence derived from a seed.
// Optional watchdog abort when PRNG_CHECK_TIMEOUT_EN is defined.
module prng_stream_checker (
  input logic                   clk,
  input logic                   rst_n,
  prng_stream_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  state_t      r_state;
  logic [31:0] r_exp;
  logic [7:0]  r_cnt;
  logic [8:0]  r_err;
  logic [7:0]  r_first;
  logic        r_seen;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic        w_mis;
  logic [8:0]  w_err_nxt;

  assign w_mis     = (bus.rand_num != r_exp);
  assign w_err_nxt = r_err + {8'd0, w_mis};

`ifdef PRNG_CHECK_TIMEOUT_EN
  logic [9:0] r_wd;
  logic       r_timeout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
`ifdef PRNG_CHECK_TIMEOUT_EN
      r_wd      <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
`ifdef PRNG_CHECK_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.seed_valid) begin
            r_exp   <= xs(bus.seed_in);
            r_cnt   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_seen  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CHECK;
`ifdef PRNG_CHECK_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end
        end
        CHECK: begin
          if (bus.in_valid) begin
            r_err <= w_err_nxt;
            if (w_mis && !r_seen) begin
              r_first <= r_cnt;
              r_seen  <= 1'b1;
            end
            r_exp <= xs(r_exp);
            r_cnt <= r_cnt + 8'd1;
`ifdef PRNG_CHECK_TIMEOUT_EN
            r_wd  <= '0;
`endif
            // final sample's own comparison feeds the verdict
            if (r_cnt == 8'd255) begin
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == 9'd0);
              r_state <= REPORT;
            end
          end
`ifdef PRNG_CHECK_TIMEOUT_EN
          else begin
            r_wd <= r_wd + 10'd1;
            if (r_wd == 10'd1022) begin
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_state   <= REPORT;
            end
          end
`endif
        end
        REPORT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_cnt       = r_err;
  assign bus.first_err_idx = r_first;
`ifdef PRNG_CHECK_TIMEOUT_EN
  assign bus.timeout       = r_timeout;
`else
  assign bus.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_prng_stream_checker.sv
// Scoreboard bench for prng_stream_checker: stimulus pushes expected verdicts,
// a negedge monitor pops them whenever done is seen.
module tb_prng_stream_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prng_stream_checker_if bus();
  prng_stream_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    bit         pass;
    logic [8:0] err;
    logic [7:0] idx;
    bit         to;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pass",          64'(bus.pass),          64'(e.pass));
          chk("err_cnt",       64'(bus.err_cnt),       64'(e.err));
          chk("first_err_idx", 64'(bus.first_err_idx), 64'(e.idx));
          chk("timeout",       64'(bus.timeout),       64'(e.to));
          chk("done_latency",  64'(cyc - last_k),      64'(e.lat));
        end
      end else begin
        chk("idle_pass_to", 64'({bus.pass, bus.timeout}), 64'd0);
      end
    end
  end

  bit busy_ok;

  task automatic run_seq(input logic [31:0] seed, input bit gapped, input int c1,
                         input int c2, input bit allff, input bit mid_seed);
    logic [31:0] e;
    @(negedge clk);
    bus.seed_valid = 1'b1; bus.seed_in = seed;
    @(negedge clk);
    bus.seed_valid = 1'b0;
    e = xs(seed);
    for (int i = 0; i < 256; i++) begin
      if (gapped) begin
        int g;
        g = $urandom_range(0, 20);
        for (int j = 0; j < g; j++) begin
          bus.in_valid = 1'b0;
          if (bus.busy !== 1'b1) busy_ok = 1'b0;
          @(negedge clk);
        end
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.rand_num = allff ? 32'hFFFF_FFFF : (e ^ ((i == c1 || i == c2) ? 32'h1 : 32'h0));
      if (mid_seed && i == 50) begin
        bus.seed_valid = 1'b1; bus.seed_in = 32'h1234_5678;
      end
      last_k = cyc;
      @(negedge clk);
      bus.seed_valid = 1'b0;
      e = xs(e);
    end
    bus.in_valid = 1'b0;
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bus.seed_valid = 1'b0; bus.seed_in = '0; bus.in_valid = 1'b0; bus.rand_num = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({bus.busy, bus.done, bus.pass, bus.timeout, bus.err_cnt, bus.first_err_idx}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.rand_num = 32'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_ignores_in_valid", 64'({bus.busy, bus.err_cnt}), 64'd0);

    // first expected word of seed 1 is 0x00042021 by hand
    chk("xs_seed1_model", 64'(xs(32'h1)), 64'h0004_2021);

    sb.push_back('{pass: 1'b1, err: 9'd0, idx: 8'd0, to: 1'b0, lat: 1});
    run_seq(32'h0000_0001, 1'b0, -1, -1, 1'b0, 1'b0);
    drain("drain_clean");

    sb.push_back('{pass: 1'b0, err: 9'd2, idx: 8'd5, to: 1'b0, lat: 1});
    run_seq(32'h0000_0001, 1'b0, 5, 200, 1'b0, 1'b0);
    drain("drain_corrupt");
    repeat (5) @(negedge clk);
    chk("hold_err_cnt", 64'(bus.err_cnt), 64'd2);
    chk("hold_first_idx", 64'(bus.first_err_idx), 64'd5);
    chk("hold_busy_low", 64'(bus.busy), 64'd0);

    busy_ok = 1'b1;
    sb.push_back('{pass: 1'b1, err: 9'd0, idx: 8'd0, to: 1'b0, lat: 1});
    run_seq(32'hDEAD_BEEF, 1'b1, -1, -1, 1'b0, 1'b0);
    chk("busy_continuous", 64'(busy_ok), 64'd1);
    drain("drain_gapped");

    sb.push_back('{pass: 1'b0, err: 9'd256, idx: 8'd0, to: 1'b0, lat: 1});
    run_seq(32'h0000_0000, 1'b0, -1, -1, 1'b1, 1'b1);
    // seed during the REPORT cycle must be dropped
    bus.seed_valid = 1'b1; bus.seed_in = 32'h0000_0001;
    @(negedge clk);
    bus.seed_valid = 1'b0;
    chk("report_seed_dropped", 64'(bus.busy), 64'd0);
    drain("drain_allff");
    repeat (3) @(negedge clk);
    chk("allff_hold_err", 64'(bus.err_cnt), 64'd256);

    // reset after 100 samples
    begin
      logic [31:0] e;
      @(negedge clk);
      bus.seed_valid = 1'b1; bus.seed_in = 32'h0000_0001;
      @(negedge clk);
      bus.seed_valid = 1'b0;
      e = xs(32'h1);
      for (int i = 0; i < 100; i++) begin
        bus.in_valid = 1'b1; bus.rand_num = (i == 3) ? ~e : e;
        @(negedge clk);
        e = xs(e);
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_err", 64'(bus.err_cnt), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outs", 64'({bus.busy, bus.done, bus.pass, bus.timeout, bus.err_cnt, bus.first_err_idx}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("post_reset_idle", 64'({bus.busy, bus.err_cnt}), 64'd0);
    end

`ifdef PRNG_CHECK_TIMEOUT_EN
    // done rises once the watchdog has counted 1023 idle cycles
    begin
      logic [31:0] e;
      sb.push_back('{pass: 1'b0, err: 9'd0, idx: 8'd0, to: 1'b1, lat: 1024});
      @(negedge clk);
      bus.seed_valid = 1'b1; bus.seed_in = 32'h0000_0001;
      @(negedge clk);
      bus.seed_valid = 1'b0;
      e = xs(32'h1);
      for (int i = 0; i < 10; i++) begin
        bus.in_valid = 1'b1; bus.rand_num = e; last_k = cyc;
        @(negedge clk);
        e = xs(e);
      end
      bus.in_valid = 1'b0;
      drain("drain_timeout");
      @(negedge clk);
      chk("timeout_busy_low", 64'(bus.busy), 64'd0);
    end
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
